modport_bridge: RTL and testbench



---
 rtl/modport_bridge.sv | 127 ++++++++++++
 tb/tb_modport_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modport_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : modport_bridge
//  Purpose  : AHB-Lite slave to APB master bridge. Each accepted AHB transfer
//             becomes one APB SETUP/ACCESS sequence. The AHB data phase is
//             stalled via hreadyouts until the APB slave completes. Read data
//             and the OKAY/ERROR response are returned to the AHB side.
//  Ports    : clock, reset            - clock, synchronous active-high reset
//             haddrs/hsels/hwrites/htranss/hsizes/hbursts/hreadys/hwdatas
//                                     - AHB-Lite slave request side
//             hreadyouts/hresps/hrdatas - AHB-Lite slave response side
//             psel/penable/pwrite/paddr/pwdata - APB master request side
//             prdata/pslverr/pready   - APB master response side
//  Revision : 1.0 - initial release
// ============================================================================
module modport_bridge (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] haddrs,
    input  logic        hsels,
    input  logic        hwrites,
    input  logic [1:0]  htranss,
    input  logic [2:0]  hsizes,
    input  logic [2:0]  hbursts,
    input  logic        hreadys,
    input  logic [31:0] hwdatas,
    input  logic [31:0] prdata,
    input  logic        pslverr,
    input  logic        pready,
    output logic        hreadyouts,
    output logic [1:0]  hresps,
    output logic [31:0] hrdatas,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic        r_write;
    logic        w_idle_like;
    logic        w_acc;
    logic        w_bad_size;
    logic        w_unused;

    // Burst type carries no meaning here: every beat is an independent transfer.
    assign w_unused = ^hbursts;

    // States in which a new address phase may be accepted (AHB sees ready).
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_acc       = w_idle_like & hsels & hreadys & htranss[1];
    assign w_bad_size  = (hsizes > 3'b010);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (w_acc) begin
                    if (w_bad_size)   w_next = S_ERR1;
                    else if (hwrites) w_next = S_WDATA;
                    else              w_next = S_SETUP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WDATA:  w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: begin
                if (pready) w_next = pslverr ? S_ERR1 : S_DONE;
            end
            S_ERR1:   w_next = S_ERR2;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= 32'h0;
            r_write <= 1'b0;
            paddr   <= 32'h0;
            pwrite  <= 1'b0;
            pwdata  <= 32'h0;
            hrdatas <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_addr  <= haddrs;
                r_write <= hwrites;
            end
            // A read goes straight from the address phase into SETUP, so the
            // APB address must come from the bus itself in that case; a write
            // enters SETUP from WDATA and uses the latched copy.
            if (w_next == S_SETUP) begin
                paddr  <= w_acc ? haddrs  : r_addr;
                pwrite <= w_acc ? hwrites : r_write;
            end
            if (r_state == S_WDATA) begin
                pwdata <= hwdatas;
            end
            if ((r_state == S_ACCESS) && pready && !pslverr && !pwrite) begin
                hrdatas <= prdata;
            end
        end
    end

    // Control outputs decode directly from the state register.
    assign psel       = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign penable    = (r_state == S_ACCESS);
    assign hreadyouts = w_idle_like;
    assign hresps     = {1'b0, (r_state == S_ERR1) || (r_state == S_ERR2)};

endmodule
`default_nettype wire

// File: tb/tb_modport_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modport_bridge
//  Purpose  : Self-checking bench for modport_bridge. Table of AHB transfers
//             with hand-computed expectations, plus directed sequences for
//             reset, IDLE/BUSY transfers and reset during an APB access.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modport_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] haddrs;
    logic        hsels;
    logic        hwrites;
    logic [1:0]  htranss;
    logic [2:0]  hsizes;
    logic [2:0]  hbursts;
    logic        hreadys;
    logic [31:0] hwdatas;
    logic [31:0] prdata;
    logic        pslverr;
    logic        pready;
    logic        hreadyouts;
    logic [1:0]  hresps;
    logic [31:0] hrdatas;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    int n_checks = 0;
    int n_fail   = 0;

    modport_bridge dut (
        .clock      (clock),
        .reset      (reset),
        .haddrs     (haddrs),
        .hsels      (hsels),
        .hwrites    (hwrites),
        .htranss    (htranss),
        .hsizes     (hsizes),
        .hbursts    (hbursts),
        .hreadys    (hreadys),
        .hwdatas    (hwdatas),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .pready     (pready),
        .hreadyouts (hreadyouts),
        .hresps     (hresps),
        .hrdatas    (hrdatas),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] rdata;
        int          waits;      // ACCESS cycles with pready low
        logic        err;        // pslverr on the completing cycle
        int          exp_cycles; // AHB data-phase length in cycles
        logic [1:0]  exp_resp;
        logic [31:0] exp_hrdata;
        int          exp_pen;    // cycles with psel & penable
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Issues one transfer starting from a ready cycle and follows it to the
    // cycle where hreadyouts returns high; acts as the APB slave meanwhile.
    task automatic run_vec(input int idx, input vec_t v);
        int         cyc;
        int         pen;
        int         setups;
        int         waits;
        logic [1:0] low_resp;
        hsels   = 1'b1;
        htranss = 2'b10;
        haddrs  = v.addr;
        hwrites = v.wr;
        hsizes  = v.size;
        hreadys = 1'b1;
        step();
        hsels    = 1'b0;
        htranss  = 2'b00;
        haddrs   = 32'h0;
        hwdatas  = v.wdata;
        prdata   = v.rdata;
        cyc      = 1;
        pen      = 0;
        setups   = 0;
        waits    = v.waits;
        low_resp = 2'b00;
        while (hreadyouts !== 1'b1 && cyc < 40) begin
            if (psel === 1'b1 && penable === 1'b0) begin
                setups++;
                chk($sformatf("v%0d setup paddr", idx), paddr, v.addr);
                chk($sformatf("v%0d setup pwrite", idx), {31'h0, pwrite}, {31'h0, v.wr});
                if (v.wr) chk($sformatf("v%0d setup pwdata", idx), pwdata, v.wdata);
            end
            if (psel === 1'b1 && penable === 1'b1) begin
                pen++;
                pready  = (waits == 0);
                pslverr = v.err && (waits == 0);
                waits--;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
            end
            low_resp = hresps;
            step();
            cyc++;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        chk($sformatf("v%0d data phase cycles", idx), cyc, v.exp_cycles);
        chk($sformatf("v%0d penable cycles", idx), pen, v.exp_pen);
        chk($sformatf("v%0d setup count", idx), setups, (v.exp_pen > 0) ? 1 : 0);
        chk($sformatf("v%0d hresps", idx), {30'h0, hresps}, {30'h0, v.exp_resp});
        chk($sformatf("v%0d hrdatas", idx), hrdatas, v.exp_hrdata);
        chk($sformatf("v%0d psel at end", idx), {31'h0, psel}, 32'h0);
        if (v.exp_resp == 2'b01)
            chk($sformatf("v%0d first error cycle resp", idx), {30'h0, low_resp}, 32'h1);
    endtask

    initial begin
        //            wr    addr          wdata         size   rdata         w  err cyc resp   hrdata        pen
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'd2, 32'h0,        0, 1'b0, 4, 2'b00, 32'h0,        1};
        vecs[1] = '{1'b0, 32'h0000_0024, 32'h0,        3'd2, 32'h1234_5678, 2, 1'b0, 5, 2'b00, 32'h1234_5678, 3};
        vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,        3'd2, 32'hAAAA_5555, 0, 1'b1, 4, 2'b01, 32'h1234_5678, 1};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,        3'd3, 32'h5555_AAAA, 0, 1'b0, 2, 2'b01, 32'h1234_5678, 0};
        vecs[4] = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 3'd0, 32'h0,        1, 1'b0, 5, 2'b00, 32'h1234_5678, 2};
        vecs[5] = '{1'b0, 32'h0000_0048, 32'h0,        3'd1, 32'h0BAD_F00D, 0, 1'b0, 3, 2'b00, 32'h0BAD_F00D, 1};
        vecs[6] = '{1'b1, 32'h0000_0050, 32'h1111_2222, 3'd2, 32'h0,        0, 1'b1, 5, 2'b01, 32'h0BAD_F00D, 1};
        vecs[7] = '{1'b0, 32'h0000_0054, 32'h0,        3'd2, 32'h7654_3210, 0, 1'b0, 3, 2'b00, 32'h7654_3210, 1};

        reset   = 1'b1;
        haddrs  = 32'h0;
        hsels   = 1'b0;
        hwrites = 1'b0;
        htranss = 2'b00;
        hsizes  = 3'd2;
        hbursts = 3'd0;
        hreadys = 1'b1;
        hwdatas = 32'h0;
        prdata  = 32'h0;
        pslverr = 1'b0;
        pready  = 1'b0;
        step();
        step();
        chk("reset hreadyouts", {31'h0, hreadyouts}, 32'h1);
        chk("reset hresps", {30'h0, hresps}, 32'h0);
        chk("reset hrdatas", hrdatas, 32'h0);
        chk("reset psel", {31'h0, psel}, 32'h0);
        chk("reset penable", {31'h0, penable}, 32'h0);
        chk("reset pwrite", {31'h0, pwrite}, 32'h0);
        chk("reset paddr", paddr, 32'h0);
        chk("reset pwdata", pwdata, 32'h0);
        reset = 1'b0;
        step();

        // Transfers run back to back: each new address is presented in the
        // DONE or ERR2 cycle of the one before.
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // IDLE, BUSY and not-ready NONSEQ must all be ignored.
        hsels   = 1'b1;
        haddrs  = 32'h0000_0070;
        htranss = 2'b00;
        step();
        chk("idle psel", {31'h0, psel}, 32'h0);
        chk("idle hreadyouts", {31'h0, hreadyouts}, 32'h1);
        htranss = 2'b01;
        step();
        chk("busy psel", {31'h0, psel}, 32'h0);
        chk("busy hresps", {30'h0, hresps}, 32'h0);
        htranss = 2'b10;
        hreadys = 1'b0;
        step();
        chk("hreadys low psel", {31'h0, psel}, 32'h0);
        chk("hreadys low hreadyouts", {31'h0, hreadyouts}, 32'h1);
        hsels   = 1'b0;
        htranss = 2'b00;
        hreadys = 1'b1;
        step();
        chk("no access pwdata held", pwdata, 32'h1111_2222);

        // Reset arriving while the APB access is waiting on the slave.
        hsels   = 1'b1;
        htranss = 2'b10;
        hwrites = 1'b0;
        hsizes  = 3'd2;
        haddrs  = 32'h0000_0060;
        step();
        hsels   = 1'b0;
        htranss = 2'b00;
        step();
        chk("pre-reset penable", {31'h0, penable}, 32'h1);
        reset = 1'b1;
        step();
        chk("mid reset psel", {31'h0, psel}, 32'h0);
        chk("mid reset penable", {31'h0, penable}, 32'h0);
        chk("mid reset hreadyouts", {31'h0, hreadyouts}, 32'h1);
        chk("mid reset hresps", {30'h0, hresps}, 32'h0);
        chk("mid reset hrdatas", hrdatas, 32'h0);
        chk("mid reset paddr", paddr, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("post reset psel", {31'h0, psel}, 32'h0);
        chk("post reset hreadyouts", {31'h0, hreadyouts}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
